// File: rtl/layer2_product_feeder_pkg.sv
// Shared layer-2 parameters: operand width, group size, adder-tree depth and
// the feeder state encodings.
package layer2_product_feeder_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int LANES       = 8;
  localparam int PIPE_STAGES = 4;
  localparam int LANE_BITS   = 3;
  localparam int GROUP_BITS  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // True when the lane index points at the final slot of a group.
  function automatic logic is_last_lane(input logic [LANE_BITS-1:0] lane);
    return lane == 3'd7;
  endfunction

endpackage

// File: rtl/layer2_product_feeder_if.sv
// Bundle of the feeder's run-control, beat and adder-tree strobe signals.
interface layer2_product_feeder_if;
  import layer2_product_feeder_pkg::*;

  logic                          i_start;
  logic [GROUP_BITS-1:0]         i_num_groups;
  logic                          i_valid;
  logic [DATA_WIDTH-1:0]         i_data;
  logic [DATA_WIDTH-1:0]         i_weight;
  logic                          o_ready;
  logic [DATA_WIDTH*LANES-1:0]   o_pipeline_layer2;
  logic                          o_valid_in_bias;
  logic [PIPE_STAGES-1:0]        o_valid_pipeline;
  logic                          o_busy;
  logic                          o_done;

  modport master (
    output i_start, i_num_groups, i_valid, i_data, i_weight,
    input  o_ready, o_pipeline_layer2, o_valid_in_bias, o_valid_pipeline,
           o_busy, o_done
  );

  modport slave (
    input  i_start, i_num_groups, i_valid, i_data, i_weight,
    output o_ready, o_pipeline_layer2, o_valid_in_bias, o_valid_pipeline,
           o_busy, o_done
  );

endinterface

// File: rtl/layer2_product_feeder_mul_fp.sv
// Combinational FP32 multiplier (sibling of Add_FP). Subnormal inputs and
// results flush to signed zero; rounding is round-to-nearest-even.
module Mul_FP (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] p
);

  logic        sign_s;
  logic [7:0]  ea_s, eb_s;
  logic [22:0] ma_s, mb_s;
  logic        a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
  logic [47:0] prod_s;
  logic [23:0] mant_s, mant_rnd_s;
  logic [9:0]  exp_s, exp_rnd_s;
  logic        guard_s, sticky_s, round_up_s;

  // Operand decode, significand product, normalisation, rounding and special-case selection.
  always_comb begin
    sign_s   = a[31] ^ b[31];
    ea_s     = a[30:23];
    eb_s     = b[30:23];
    ma_s     = a[22:0];
    mb_s     = b[22:0];
    a_zero_s = (ea_s == 8'd0);
    b_zero_s = (eb_s == 8'd0);
    a_inf_s  = (ea_s == 8'hFF) && (ma_s == 23'd0);
    b_inf_s  = (eb_s == 8'hFF) && (mb_s == 23'd0);
    a_nan_s  = (ea_s == 8'hFF) && (ma_s != 23'd0);
    b_nan_s  = (eb_s == 8'hFF) && (mb_s != 23'd0);
    prod_s   = {24'd0, 1'b1, ma_s} * {24'd0, 1'b1, mb_s};

    if (prod_s[47]) begin
      mant_s   = {1'b0, prod_s[46:24]};
      guard_s  = prod_s[23];
      sticky_s = |prod_s[22:0];
      exp_s    = {2'b00, ea_s} + {2'b00, eb_s} - 10'd126;
    end else begin
      mant_s   = {1'b0, prod_s[45:23]};
      guard_s  = prod_s[22];
      sticky_s = |prod_s[21:0];
      exp_s    = {2'b00, ea_s} + {2'b00, eb_s} - 10'd127;
    end

    round_up_s = guard_s & (sticky_s | mant_s[0]);
    mant_rnd_s = mant_s + {23'd0, round_up_s};
    if (mant_rnd_s[23]) begin
      exp_rnd_s = exp_s + 10'd1;
    end else begin
      exp_rnd_s = exp_s;
    end

    if (a_nan_s || b_nan_s) begin
      p = 32'h7FC0_0000;
    end else if (a_inf_s || b_inf_s) begin
      if (a_zero_s || b_zero_s) begin
        p = 32'h7FC0_0000;
      end else begin
        p = {sign_s, 8'hFF, 23'd0};
      end
    end else if (a_zero_s || b_zero_s) begin
      p = {sign_s, 31'd0};
    end else if (exp_rnd_s[9] || (exp_rnd_s == 10'd0)) begin
      p = {sign_s, 31'd0};
    end else if (exp_rnd_s[8:0] >= 9'd255) begin
      p = {sign_s, 8'hFF, 23'd0};
    end else begin
      p = {sign_s, exp_rnd_s[7:0], mant_rnd_s[22:0]};
    end
  end

endmodule

// File: rtl/layer2_product_feeder.sv
// Collects FP32 activation*weight products into groups of eight, presents each
// full group to the layer-2 adder tree and walks a valid strobe down its stages.
module layer2_product_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  layer2_product_feeder_if.slave  bus
);
  import layer2_product_feeder_pkg::*;

  state_t                       state_r;
  logic [LANE_BITS-1:0]         lane_cnt_r;
  logic [GROUP_BITS-1:0]        group_cnt_r;
  logic [DATA_WIDTH-1:0]        fill_r [LANES];
  logic [DATA_WIDTH*LANES-1:0]  pipe_r;
  logic [PIPE_STAGES:0]         valid_sr_r;
  logic                         ready_r;
  logic                         busy_r;
  logic                         done_r;
  logic [DATA_WIDTH-1:0]        product_s;
  logic                         beat_s;
  logic                         last_beat_s;

  Mul_FP u_mul_fp (
    .a (bus.i_data),
    .b (bus.i_weight),
    .p (product_s)
  );

  // Beat qualification: only beats offered while ready count.
  always_comb begin
    beat_s      = bus.i_valid & ready_r;
    last_beat_s = beat_s & is_last_lane(lane_cnt_r);
  end

  // Fill buffer: each accepted product lands in the current lane.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LANES; k++) begin
        fill_r[k] <= '0;
      end
    end else if (beat_s) begin
      fill_r[lane_cnt_r] <= product_s;
    end
  end

  // Output register: snapshot of the full group, held until the next group completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_r <= '0;
    end else if (last_beat_s) begin
      for (int k = 0; k < LANES - 1; k++) begin
        pipe_r[k*DATA_WIDTH +: DATA_WIDTH] <= fill_r[k];
      end
      pipe_r[(LANES-1)*DATA_WIDTH +: DATA_WIDTH] <= product_s;
    end
  end

  // Strobe shift register: one token per completed group, overlapping groups allowed.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_sr_r <= '0;
    end else begin
      valid_sr_r <= {valid_sr_r[PIPE_STAGES-1:0], last_beat_s};
    end
  end

  // Run-control state machine with registered ready/busy/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      lane_cnt_r  <= 3'd0;
      group_cnt_r <= 16'd0;
      ready_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.i_start) begin
            if (bus.i_num_groups != 16'd0) begin
              state_r     <= ST_RUN;
              group_cnt_r <= bus.i_num_groups;
              lane_cnt_r  <= 3'd0;
              ready_r     <= 1'b1;
              busy_r      <= 1'b1;
            end else begin
              done_r <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (beat_s) begin
            lane_cnt_r <= lane_cnt_r + 3'd1;
            if (is_last_lane(lane_cnt_r)) begin
              group_cnt_r <= group_cnt_r - 16'd1;
              if (group_cnt_r == 16'd1) begin
                state_r <= ST_DRAIN;
                ready_r <= 1'b0;
              end
            end
          end
        end
        ST_DRAIN: begin
          // Last stage token marks the downstream output register as valid.
          if (valid_sr_r[PIPE_STAGES]) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          ready_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_ready           = ready_r;
  assign bus.o_busy            = busy_r;
  assign bus.o_done            = done_r;
  assign bus.o_pipeline_layer2 = pipe_r;
  assign bus.o_valid_in_bias   = valid_sr_r[0];
  assign bus.o_valid_pipeline  = valid_sr_r[PIPE_STAGES:1];

endmodule
